// File: rtl/user_prng_multi.sv
// Multi-channel xorshift32 PRNG behind an OBI subordinate port, one 16-byte register window per channel.
// Optional macro USER_PRNG_COUNT_EN adds the per-channel COUNT register of RAND reads.
module user_prng_multi #(
    parameter int unsigned NumChannels    = 4,
    parameter logic [31:0] RstSeed        = 32'hDEADBEEF,
    parameter int unsigned ADDR_WIDTH_OBI = 32,
    parameter int unsigned DATA_WIDTH_OBI = 32,
    // Stand-in default for the bus configuration's ID width
    parameter int unsigned ID_WIDTH_OBI   = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [3:0]                be_i,
    input  logic [ADDR_WIDTH_OBI-1:0] addr_i,
    input  logic [DATA_WIDTH_OBI-1:0] wdata_i,
    input  logic [ID_WIDTH_OBI-1:0]   aid_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic                      err_o,
    output logic [DATA_WIDTH_OBI-1:0] rdata_o,
    output logic [ID_WIDTH_OBI-1:0]   rid_o
);

    localparam logic [1:0] REG_RAND  = 2'd0;
    localparam logic [1:0] REG_SEED  = 2'd1;
    localparam logic [1:0] REG_CTRL  = 2'd2;
    localparam logic [1:0] REG_COUNT = 2'd3;

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 5'd13);
        t = t ^ (t >> 5'd17);
        t = t ^ (t << 5'd5);
        return t;
    endfunction

    logic [11:0] w_off;
    logic [2:0]  w_ch;
    logic [1:0]  w_reg;
    logic        w_in_range;
    logic        w_err;
    logic [31:0] w_rd_val;
    logic [31:0] w_rdata;
    logic        w_unused_addr;
    logic [31:0] w_state   [NumChannels];
    logic        w_freerun [NumChannels];
    logic [31:0] w_count   [NumChannels];

    logic                    r_rvalid;
    logic                    r_err;
    logic [31:0]             r_rdata;
    logic [ID_WIDTH_OBI-1:0] r_rid;

    assign w_off         = addr_i[11:0];
    assign w_ch          = w_off[6:4];
    assign w_reg         = w_off[3:2];
    assign w_in_range    = (w_off < 12'h080) && (32'(w_ch) < NumChannels);
    assign w_unused_addr = ^{addr_i[ADDR_WIDTH_OBI-1:12], addr_i[1:0]};
    assign gnt_o         = req_i;

    // Error classification of the current request
    always_comb begin
        w_err = 1'b0;
        if (!w_in_range) begin
            w_err = 1'b1;
        end else begin
            case (w_reg)
                REG_RAND:  w_err = we_i;
                REG_SEED:  w_err = we_i && (be_i != 4'hF);
                REG_CTRL:  w_err = 1'b0;
`ifdef USER_PRNG_COUNT_EN
                REG_COUNT: w_err = we_i;
`else
                REG_COUNT: w_err = 1'b1;
`endif
                default:   w_err = 1'b1;
            endcase
        end
    end

    // Read-data mux across channels and registers
    always_comb begin
        w_rd_val = 32'd0;
        for (int c = 0; c < NumChannels; c++) begin
            if (w_ch == 3'(c)) begin
                case (w_reg)
                    REG_RAND:  w_rd_val = w_state[c];
                    REG_SEED:  w_rd_val = w_state[c];
                    REG_CTRL:  w_rd_val = {31'd0, w_freerun[c]};
                    REG_COUNT: w_rd_val = w_count[c];
                    default:   w_rd_val = 32'd0;
                endcase
            end else begin
                w_rd_val = w_rd_val;
            end
        end
        if (!we_i && !w_err) begin
            w_rdata = w_rd_val;
        end else begin
            w_rdata = 32'd0;
        end
    end

    for (genvar c = 0; c < NumChannels; c++) begin : g_ch
        logic        w_sel;
        logic        w_seed_load;
        logic        w_rand_rd;
        logic [31:0] r_state;
        logic        r_freerun;

        assign w_sel       = req_i && w_in_range && (w_ch == 3'(c));
        assign w_seed_load = w_sel && we_i && (w_reg == REG_SEED) && (be_i == 4'hF);
        assign w_rand_rd   = w_sel && !we_i && (w_reg == REG_RAND);

        // Seed load has priority over any advance; a RAND read during FREERUN is still one step
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_state <= RstSeed + 32'(c);
            end else if (w_seed_load) begin
                r_state <= (wdata_i == 32'd0) ? 32'd1 : wdata_i;
            end else if (w_rand_rd || r_freerun) begin
                r_state <= xorshift32(r_state);
            end
        end

        // FREERUN control bit
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_freerun <= 1'b0;
            end else if (w_sel && we_i && (w_reg == REG_CTRL)) begin
                r_freerun <= wdata_i[0];
            end
        end

`ifdef USER_PRNG_COUNT_EN
        logic [31:0] r_count;

        // RAND-read counter, cleared by a seed load
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_count <= 32'd0;
            end else if (w_seed_load) begin
                r_count <= 32'd0;
            end else if (w_rand_rd) begin
                r_count <= r_count + 32'd1;
            end
        end
        assign w_count[c] = r_count;
`else
        assign w_count[c] = 32'd0;
`endif
        assign w_state[c]   = r_state;
        assign w_freerun[c] = r_freerun;
    end

    // Registered response, one cycle after each granted request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= 32'd0;
            r_rid    <= '0;
        end else if (req_i) begin
            r_rvalid <= 1'b1;
            r_err    <= w_err;
            r_rdata  <= w_rdata;
            r_rid    <= aid_i;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= 32'd0;
        end
    end

    assign rvalid_o = r_rvalid;
    assign err_o    = r_err;
    assign rdata_o  = r_rdata;
    assign rid_o    = r_rid;

endmodule

// File: tb/tb_user_prng_multi.sv
// Scoreboard bench for user_prng_multi: expectations are queued at request time and popped on rvalid_o.
module tb_user_prng_multi;

    localparam int IDW = 4;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b1;
    logic            req_i = 1'b0;
    logic            we_i = 1'b0;
    logic [3:0]      be_i = 4'h0;
    logic [31:0]     addr_i = 32'd0;
    logic [31:0]     wdata_i = 32'd0;
    logic [IDW-1:0]  aid_i = '0;
    logic            gnt_o;
    logic            rvalid_o;
    logic            err_o;
    logic [31:0]     rdata_o;
    logic [IDW-1:0]  rid_o;

    user_prng_multi #(
        .NumChannels(4),
        .RstSeed(32'hDEADBEEF),
        .ADDR_WIDTH_OBI(32),
        .DATA_WIDTH_OBI(32),
        .ID_WIDTH_OBI(IDW)
    ) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .be_i(be_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .aid_i(aid_i), .gnt_o(gnt_o),
        .rvalid_o(rvalid_o), .err_o(err_o), .rdata_o(rdata_o), .rid_o(rid_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string          tag;
        logic           err;
        logic [31:0]    rdata;
        logic [IDW-1:0] rid;
    } exp_t;

    exp_t           sb_q[$];
    exp_t           m_e;
    int             n_cmp = 0;
    int             n_bad = 0;
    logic [IDW-1:0] next_id = '0;
    logic [31:0]    s0, s2, s3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference step written with explicit bit slicing
    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ {x[18:0], 13'b0};
        y = y ^ {17'b0, y[31:17]};
        y = y ^ {y[26:0], 5'b0};
        return y;
    endfunction

    task automatic xfer(input string tag, input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd);
        exp_t e;
        @(negedge clk_i);
        req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wd; aid_i = next_id;
        e.tag = tag; e.err = e_err; e.rdata = e_rd; e.rid = next_id;
        sb_q.push_back(e);
        next_id = next_id + 4'd1;
        #1 chk({tag, "_gnt"}, 32'(gnt_o), 32'd1);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] e_rd);
        xfer(tag, 1'b0, addr, 4'hF, 32'd0, 1'b0, e_rd);
    endtask

    task automatic rd_err(input string tag, input logic [31:0] addr);
        xfer(tag, 1'b0, addr, 4'hF, 32'd0, 1'b1, 32'd0);
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, input logic e_err);
        xfer(tag, 1'b1, addr, be, wd, e_err, 32'd0);
    endtask

    task automatic idle();
        @(negedge clk_i);
        req_i = 1'b0; we_i = 1'b0;
        #1 chk("gnt_idle", 32'(gnt_o), 32'd0);
    endtask

    // Response monitor: pop one expectation per rvalid_o
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (rvalid_o) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_rvalid", 32'd1, 32'd0);
                end else begin
                    m_e = sb_q.pop_front();
                    chk({m_e.tag, "_err"}, 32'(err_o), 32'(m_e.err));
                    chk({m_e.tag, "_rdata"}, rdata_o, m_e.rdata);
                    chk({m_e.tag, "_rid"}, 32'(rid_o), 32'(m_e.rid));
                end
            end else begin
                chk("idle_rdata", rdata_o, 32'd0);
            end
        end
    end

    initial begin
        #1 rst_ni = 1'b0;
        #1;
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_rid", 32'(rid_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        s0 = 32'hDEADBEEF;
        rd("c0_rand0", 32'h000, 32'hDEADBEEF); s0 = xs(s0);
        rd("c0_rand1", 32'h000, s0);           s0 = xs(s0);
        rd("c0_seed_rd", 32'h004, s0);
        rd("c0_seed_rd2", 32'h004, s0);

        wr("c1_seed0", 32'h014, 4'hF, 32'd0, 1'b0);
        rd("c1_rand_a", 32'h010, 32'h00000001);
        rd("c1_rand_b", 32'h010, 32'h00042021);
        rd("c0_untouched", 32'h004, s0);

        wr("c0_seed_be3", 32'h004, 4'h3, 32'h0000_0055, 1'b1);
        rd("c0_after_be3", 32'h004, s0);
        wr("c0_wr_rand", 32'h000, 4'hF, 32'd5, 1'b1);
        rd("c0_after_wrrand", 32'h004, s0);
        rd_err("oor_0x40", 32'h040);
        rd_err("oor_0x80", 32'h080);
        wr("oor_wr_0x44", 32'h044, 4'hF, 32'd7, 1'b1);
        rd_err("oor_0xffc", 32'h0000_0FFC);
        wr("c0_wr_count", 32'h00C, 4'hF, 32'd0, 1'b1);
        rd("c3_seed_rst", 32'h034, 32'hDEADBEF2);
        rd("c3_hi_addr", 32'hABCD_1034, 32'hDEADBEF2);
        rd("c2_ctrl_rst", 32'h028, 32'd0);

        // FREERUN on channel 2: it starts advancing on the edge after the CTRL write
        wr("c2_seed1", 32'h024, 4'hF, 32'd1, 1'b0);
        wr("c2_fr_on", 32'h028, 4'hF, 32'hFFFF_FFFF, 1'b0);
        s2 = 32'd1;
        rd("c2_seed_e3", 32'h024, s2);  s2 = xs(s2);
        idle();                         s2 = xs(s2);
        rd("c2_seed_e5", 32'h024, s2);  s2 = xs(s2);
        rd("c2_rand_fr", 32'h020, s2);  s2 = xs(s2);
        rd("c2_seed_e7", 32'h024, s2);  s2 = xs(s2);
        rd("c2_ctrl_on", 32'h028, 32'd1); s2 = xs(s2);
        wr("c2_seed_fr", 32'h024, 4'hF, 32'h12345678, 1'b0); s2 = 32'h12345678;
        rd("c2_seed_loaded", 32'h024, s2); s2 = xs(s2);
        wr("c2_fr_off", 32'h028, 4'hF, 32'd0, 1'b0); s2 = xs(s2);
        rd("c2_seed_stop", 32'h024, s2);
        rd("c2_seed_hold", 32'h024, s2);
        rd("c0_after_fr", 32'h004, s0);

        s3 = 32'hDEADBEF2;
        for (int i = 0; i < 3; i++) begin
            rd("c3_rand", 32'h030, s3); s3 = xs(s3);
        end
`ifdef USER_PRNG_COUNT_EN
        rd("c3_count3", 32'h03C, 32'd3);
        wr("c3_seed", 32'h034, 4'hF, 32'h0000_CAFE, 1'b0);
        rd("c3_count0", 32'h03C, 32'd0);
        rd("c3_seed_cafe", 32'h034, 32'h0000_CAFE);
`else
        rd_err("c3_count_dis", 32'h03C);
`endif
        repeat (3) idle();
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        // Reset asserted while a read response is pending
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h004; be_i = 4'hF; aid_i = 4'hA;
        @(posedge clk_i);
        #1 rst_ni = 1'b0;
        #1;
        chk("arst_rvalid", 32'(rvalid_o), 32'd0);
        chk("arst_err", 32'(err_o), 32'd0);
        chk("arst_rdata", rdata_o, 32'd0);
        chk("arst_rid", 32'(rid_o), 32'd0);
        req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("no_resp_after_rst", 32'(rvalid_o), 32'd0);
        end

        rd("c0_rand_rst", 32'h000, 32'hDEADBEEF);
        rd("c2_ctrl_rst2", 32'h028, 32'd0);
        rd("c2_seed_rst", 32'h024, 32'hDEADBEF1);
        rd("c1_seed_rst", 32'h014, 32'hDEADBEF0);
`ifdef USER_PRNG_COUNT_EN
        rd("c3_count_rst", 32'h03C, 32'd0);
`endif
        repeat (3) idle();
        chk("sb_drain_end", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
